move_queue: RTL and testbench
=============================

MOVE_QUEUE -- requirements
Module: move_queue

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth; power of two, 2..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream move command present.
REQ-005 in_ready  output  1  queue can accept; equals (count < DEPTH) && !fault.
REQ-006 in_speed  input  32  feed rate, microsteps/s.
REQ-007 in_num_x, in_num_y, in_num_z, in_num_e0, in_num_e1  input  32 each, signed  relative move per axis, microsteps.
REQ-008 speed  output  32  registered speed of the move being executed.
REQ-009 num_x_m, num_y_m, num_z_m, num_e0_m, num_e1_m  output  32 each, signed  registered axis counts of the move being executed.
REQ-010 start_driving_main  output  1  level request to the motion stage.
REQ-011 finish  input  1  motion stage done (sampled only in RUN).
REQ-012 error  input  1  motion stage endstop error (sampled only in RUN).
REQ-013 clear_fault  input  1  one-cycle pulse that leaves FAULT.
REQ-014 busy  output  1  high in RUN or GAP, or when count > 0.
REQ-015 count  output  clog2(DEPTH)+1  number of queued, not-yet-issued commands.
REQ-016 fault  output  1  high exactly in state FAULT.

Function
REQ-017 Push: on an edge where in_valid && in_ready, store {in_speed, five nums} at the write pointer, advance it modulo DEPTH, count+1.
REQ-018 Pointers wrap modulo DEPTH; FIFO order is strictly preserved.
REQ-019 Pop and push in the same cycle leave count unchanged, and both entries are handled correctly.
REQ-020 No push occurs while count == DEPTH or fault == 1; in_valid is ignored then, and no data is lost or overwritten.
REQ-021 FSM states: IDLE, RUN, GAP, FAULT.
REQ-022 IDLE, count > 0, head all five nums zero: pop and discard, no issue, stay IDLE.
REQ-023 IDLE, count > 0, any num nonzero: pop, load speed/num_*_m from head, set start_driving_main=1, next RUN; all at one edge.
REQ-024 A command accepted into an empty queue in IDLE yields start_driving_main=1 at the first rising edge after the accepting edge.
REQ-025 RUN: speed/num_*_m held constant; start_driving_main stays 1.
REQ-026 RUN, error==1: start_driving_main=0, flush FIFO (count=0, pointers equal), next FAULT; error takes priority over finish.
REQ-027 RUN, finish==1, error==0: start_driving_main=0, next GAP.
REQ-028 GAP lasts exactly one cycle with start_driving_main=0, then IDLE.
REQ-029 The GAP cycle guarantees at least one low cycle between consecutive moves.
REQ-030 FAULT: start_driving_main=0, in_ready=0, outputs hold last move; clear_fault==1 -> IDLE next edge.
REQ-031 finish, error and clear_fault are ignored in every state other than the one named above.
REQ-032 Stored and output data are passed bit-exact; no arithmetic, sign conversion or clamping is performed on them.

Reset
REQ-033 While reset is sampled high: state IDLE, pointers and count 0, start_driving_main 0, speed and all num_*_m 0, fault 0.
REQ-034 Reset overrides every other input and applies in any state, including mid-RUN; queued entries are discarded.
REQ-035 in_ready is 0 in the cycle reset is high and 1 in the first cycle after it.

Verification
REQ-036 Push {speed=1000, x=200, others 0} into empty queue -> start rises one edge later, num_x_m=200, speed=1000; finish pulse -> start low, one GAP cycle, back to IDLE.
REQ-037 DEPTH=4, push 5 commands back-to-back while RUN stalls -> in_ready drops after the 4th, 5th is held off; entries issue in order 1..4 with GAP between each.
REQ-038 Queue zero move then {y=-50} -> zero move consumes one IDLE cycle with no start pulse; y move issues with num_y_m=-50 (0xFFFFFFCE).
REQ-039 3 entries queued, error=1 and finish=1 together in RUN -> FAULT, count=0, start=0, in_ready=0; clear_fault -> IDLE, in_ready=1.
REQ-040 Reset asserted mid-RUN with 2 entries queued -> next edge: start=0, count=0, outputs 0, state IDLE.
REQ-041 Run more than 2*DEPTH push/pop cycles -> pointers wrap correctly and data matches the scoreboard exactly.

Source files
------------

// File: rtl/move_queue.sv
// ---------------------------------------------------------------------------
// move_queue
//
// Purpose:
//   Buffers relative move commands (feed rate plus five signed axis counts)
//   in a small FIFO and hands them one at a time to the motion stage. A
//   move is presented on the registered outputs together with a level
//   request, start_driving_main, that stays high until the motion stage
//   reports finish or error. The queue keeps at least one low cycle on
//   start_driving_main between consecutive moves. An endstop error flushes
//   every queued command and parks the block in FAULT until clear_fault.
//
// Ports:
//   clk                  rising-edge clock for all state
//   reset                synchronous, active-high reset
//   in_valid / in_ready  upstream command handshake
//   in_speed             feed rate of the offered command (microsteps/s)
//   in_num_x .. e1       signed relative move per axis (microsteps)
//   speed, num_*_m       registered command currently being executed
//   start_driving_main   level request to the motion stage
//   finish               motion stage done, only looked at while running
//   error                motion stage endstop error, only looked at while running
//   clear_fault          one-cycle pulse that leaves FAULT
//   busy                 running, in the gap cycle, or commands queued
//   count                queued commands not yet issued
//   fault                high while in FAULT
// ---------------------------------------------------------------------------
module move_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_speed,
    input  logic signed [31:0]     in_num_x,
    input  logic signed [31:0]     in_num_y,
    input  logic signed [31:0]     in_num_z,
    input  logic signed [31:0]     in_num_e0,
    input  logic signed [31:0]     in_num_e1,
    output logic [31:0]            speed,
    output logic signed [31:0]     num_x_m,
    output logic signed [31:0]     num_y_m,
    output logic signed [31:0]     num_z_m,
    output logic signed [31:0]     num_e0_m,
    output logic signed [31:0]     num_e1_m,
    output logic                   start_driving_main,
    input  logic                   finish,
    input  logic                   error,
    input  logic                   clear_fault,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   fault
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_FAULT
    } state_t;

    state_t          r_state;
    state_t          w_nextState;

    logic [191:0]    r_mem [DEPTH];
    logic [PW-1:0]   r_wrPtr;
    logic [PW-1:0]   r_rdPtr;
    logic [CW-1:0]   r_count;

    logic [31:0]     r_speed;
    logic [31:0]     r_numX;
    logic [31:0]     r_numY;
    logic [31:0]     r_numZ;
    logic [31:0]     r_numE0;
    logic [31:0]     r_numE1;
    logic            r_start;

    logic [191:0]    w_entry;
    logic [191:0]    w_head;
    logic            w_headZero;
    logic            w_canAccept;
    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic            w_flush;

    // Entry layout: speed in the top word, then x, y, z, e0, e1.
    assign w_entry    = {in_speed, in_num_x, in_num_y, in_num_z, in_num_e0, in_num_e1};
    assign w_head     = r_mem[r_rdPtr];
    assign w_headZero = (w_head[159:0] == '0);

    // Reset is folded in so that upstream never sees a ready while the
    // queue is being cleared.
    assign w_canAccept = !reset && (r_count < DEPTH_C) && (r_state != S_FAULT);
    assign w_push      = in_valid && w_canAccept;

    // Command storage; contents only matter between push and pop, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_entry;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. The head is popped in IDLE whether or not it is
    // issued: an all-zero move is simply dropped and IDLE tries again.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop = 1'b1;
                    if (!w_headZero) begin
                        w_issue     = 1'b1;
                        w_nextState = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (error) begin
                    w_flush     = 1'b1;
                    w_nextState = S_FAULT;
                end else if (finish) begin
                    w_nextState = S_GAP;
                end
            end
            S_GAP: begin
                w_nextState = S_IDLE;
            end
            S_FAULT: begin
                if (clear_fault) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Pointers and occupancy. A flush also drops a command accepted in the
    // same cycle, so the queue is guaranteed empty on entry to FAULT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_rdPtr <= r_wrPtr;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Move outputs load only when a command is issued and otherwise hold,
    // so the last move stays visible through GAP, IDLE and FAULT. The
    // request is high exactly while the next state is RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_speed <= '0;
            r_numX  <= '0;
            r_numY  <= '0;
            r_numZ  <= '0;
            r_numE0 <= '0;
            r_numE1 <= '0;
            r_start <= 1'b0;
        end else begin
            r_start <= (w_nextState == S_RUN);
            if (w_issue) begin
                r_speed <= w_head[191:160];
                r_numX  <= w_head[159:128];
                r_numY  <= w_head[127:96];
                r_numZ  <= w_head[95:64];
                r_numE0 <= w_head[63:32];
                r_numE1 <= w_head[31:0];
            end
        end
    end

    assign in_ready           = w_canAccept;
    assign speed              = r_speed;
    assign num_x_m            = r_numX;
    assign num_y_m            = r_numY;
    assign num_z_m            = r_numZ;
    assign num_e0_m           = r_numE0;
    assign num_e1_m           = r_numE1;
    assign start_driving_main = r_start;
    assign count              = r_count;
    assign fault              = (r_state == S_FAULT);
    assign busy               = (r_state == S_RUN) || (r_state == S_GAP) || (r_count != '0);

endmodule

// File: tb/tb_move_queue.sv
// ---------------------------------------------------------------------------
// tb_move_queue
//
// Purpose:
//   Self-checking bench for move_queue with DEPTH = 4. Every command that
//   should reach the motion stage is pushed onto a scoreboard queue when it
//   is accepted, and popped and compared when start_driving_main rises.
//   Each scenario lives in its own task and is run in sequence.
// ---------------------------------------------------------------------------
module tb_move_queue;

    localparam int DEPTH = 4;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_speed;
    logic signed [31:0] in_num_x;
    logic signed [31:0] in_num_y;
    logic signed [31:0] in_num_z;
    logic signed [31:0] in_num_e0;
    logic signed [31:0] in_num_e1;
    logic [31:0]        speed;
    logic signed [31:0] num_x_m;
    logic signed [31:0] num_y_m;
    logic signed [31:0] num_z_m;
    logic signed [31:0] num_e0_m;
    logic signed [31:0] num_e1_m;
    logic               start_driving_main;
    logic               finish;
    logic               error;
    logic               clear_fault;
    logic               busy;
    logic [2:0]         count;
    logic               fault;

    logic [191:0]       sb[$];
    logic [191:0]       sbExp;
    logic [191:0]       sbGot;
    int                 assertCount;
    int                 failCount;

    move_queue #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_speed           (in_speed),
        .in_num_x           (in_num_x),
        .in_num_y           (in_num_y),
        .in_num_z           (in_num_z),
        .in_num_e0          (in_num_e0),
        .in_num_e1          (in_num_e1),
        .speed              (speed),
        .num_x_m            (num_x_m),
        .num_y_m            (num_y_m),
        .num_z_m            (num_z_m),
        .num_e0_m           (num_e0_m),
        .num_e1_m           (num_e1_m),
        .start_driving_main (start_driving_main),
        .finish             (finish),
        .error              (error),
        .clear_fault        (clear_fault),
        .busy               (busy),
        .count              (count),
        .fault              (fault)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge, where inputs are driven
    // and outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [191:0] mk(input logic [31:0] s, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] z,
                                        input logic [31:0] e0, input logic [31:0] e1);
        return {s, x, y, z, e0, e1};
    endfunction

    function automatic logic [191:0] outs();
        return {speed, num_x_m, num_y_m, num_z_m, num_e0_m, num_e1_m};
    endfunction

    // Offers one command and returns just after the edge that accepts it;
    // in_valid is left high so callers can stream commands back to back.
    // Only moves with a nonzero axis are expected to reach the motion stage.
    task automatic push_cmd(input logic [191:0] e);
        int waitCycles;
        {in_speed, in_num_x, in_num_y, in_num_z, in_num_e0, in_num_e1} = e;
        in_valid = 1'b1;
        waitCycles = 0;
        while (!in_ready && waitCycles < 50) begin
            tick();
            waitCycles++;
        end
        if (!in_ready) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL push_timeout in_ready=%0b after %0d cycles, required 1", in_ready, waitCycles);
        end else begin
            tick();
            if (e[159:0] != '0) sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; finish = 1'b0; error = 1'b0; clear_fault = 1'b0;
        {in_speed, in_num_x, in_num_y, in_num_z, in_num_e0, in_num_e1} = '0;
        tick(); tick();
        assertCount++; if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ready got=%0b exp=0", in_ready); end
        assertCount++; if (start_driving_main !== 1'b0) begin failCount++; $display("[TB] FAIL reset_start got=%0b exp=0", start_driving_main); end
        assertCount++; if (count !== 3'd0) begin failCount++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
        assertCount++; if (fault !== 1'b0 || busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_flags fault=%0b busy=%0b exp 0 0", fault, busy); end
        assertCount++; if (outs() !== 192'd0) begin failCount++; $display("[TB] FAIL reset_outs got=%h exp=0", outs()); end
        reset = 1'b0;
        #1;
        assertCount++; if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL release_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_idle_ignore();
        finish = 1'b1; error = 1'b1; clear_fault = 1'b1;
        tick();
        finish = 1'b0; error = 1'b0; clear_fault = 1'b0;
        tick();
        assertCount++; if (fault !== 1'b0 || start_driving_main !== 1'b0 || busy !== 1'b0) begin
            failCount++; $display("[TB] FAIL idle_ignore fault=%0b start=%0b busy=%0b exp 0 0 0", fault, start_driving_main, busy);
        end
    endtask

    task automatic test_single_move();
        push_cmd(mk(32'd1000, 32'd200, 0, 0, 0, 0));
        in_valid = 1'b0;
        assertCount++; if (start_driving_main !== 1'b0 || count !== 3'd1) begin
            failCount++; $display("[TB] FAIL single_accept start=%0b count=%0d exp 0 1", start_driving_main, count);
        end
        tick();
        assertCount++; if (start_driving_main !== 1'b1) begin failCount++; $display("[TB] FAIL single_start got=%0b exp=1", start_driving_main); end
        if (sb.size() != 0) sbExp = sb.pop_front(); else sbExp = '1;
        sbGot = outs();
        assertCount++; if (sbGot !== sbExp) begin failCount++; $display("[TB] FAIL single_data got=%h exp=%h", sbGot, sbExp); end
        tick(); tick(); tick();
        assertCount++; if (start_driving_main !== 1'b1 || outs() !== sbExp) begin
            failCount++; $display("[TB] FAIL single_hold start=%0b data=%h exp 1 %h", start_driving_main, outs(), sbExp);
        end
        finish = 1'b1;
        tick();
        finish = 1'b0;
        assertCount++; if (start_driving_main !== 1'b0 || busy !== 1'b1) begin
            failCount++; $display("[TB] FAIL single_gap start=%0b busy=%0b exp 0 1", start_driving_main, busy);
        end
        tick();
        assertCount++; if (start_driving_main !== 1'b0 || busy !== 1'b0) begin
            failCount++; $display("[TB] FAIL single_idle start=%0b busy=%0b exp 0 0", start_driving_main, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [191:0] item5;
        item5 = mk(32'd1005, 32'd6, -32'sd6, 32'd10, 0, 32'd7);
        push_cmd(mk(32'd999, 32'd9, 0, 0, 0, 0));
        in_valid = 1'b0;
        tick();
        if (sb.size() != 0) sbExp = sb.pop_front(); else sbExp = '1;
        sbGot = outs();
        assertCount++; if (start_driving_main !== 1'b1 || sbGot !== sbExp) begin
            failCount++; $display("[TB] FAIL bp_first start=%0b data=%h exp 1 %h", start_driving_main, sbGot, sbExp);
        end
        for (int k = 0; k < 4; k++) begin
            push_cmd(mk(32'd1001 + k, k + 1, -(k + 1), 2 * k, 0, 32'd7));
        end
        {in_speed, in_num_x, in_num_y, in_num_z, in_num_e0, in_num_e1} = item5;
        assertCount++; if (in_ready !== 1'b0 || count !== 3'd4) begin
            failCount++; $display("[TB] FAIL bp_full ready=%0b count=%0d exp 0 4", in_ready, count);
        end
        tick(); tick();
        assertCount++; if (count !== 3'd4 || start_driving_main !== 1'b1) begin
            failCount++; $display("[TB] FAIL bp_held count=%0d start=%0b exp 4 1", count, start_driving_main);
        end
        for (int k = 0; k < 5; k++) begin
            finish = 1'b1;
            tick();
            finish = 1'b0;
            assertCount++; if (start_driving_main !== 1'b0) begin failCount++; $display("[TB] FAIL bp_gap_low[%0d] got=%0b exp=0", k, start_driving_main); end
            tick();
            assertCount++; if (start_driving_main !== 1'b0) begin failCount++; $display("[TB] FAIL bp_idle_low[%0d] got=%0b exp=0", k, start_driving_main); end
            tick();
            assertCount++; if (start_driving_main !== 1'b1) begin failCount++; $display("[TB] FAIL bp_restart[%0d] got=%0b exp=1", k, start_driving_main); end
            if (sb.size() != 0) sbExp = sb.pop_front(); else sbExp = '1;
            sbGot = outs();
            assertCount++; if (sbGot !== sbExp) begin failCount++; $display("[TB] FAIL bp_order[%0d] got=%h exp=%h", k, sbGot, sbExp); end
            if (k == 0) begin
                assertCount++; if (count !== 3'd3 || in_ready !== 1'b1) begin
                    failCount++; $display("[TB] FAIL bp_drain count=%0d ready=%0b exp 3 1", count, in_ready);
                end
                push_cmd(item5);
                in_valid = 1'b0;
            end
        end
        finish = 1'b1;
        tick();
        finish = 1'b0;
        tick();
        assertCount++; if (busy !== 1'b0 || count !== 3'd0) begin failCount++; $display("[TB] FAIL bp_end busy=%0b count=%0d exp 0 0", busy, count); end
    endtask

    task automatic test_zero_move();
        push_cmd(mk(32'd77, 0, 0, 0, 0, 0));
        push_cmd(mk(32'd500, 0, -32'sd50, 0, 0, 0));
        in_valid = 1'b0;
        assertCount++; if (start_driving_main !== 1'b0 || count !== 3'd1) begin
            failCount++; $display("[TB] FAIL zero_skip start=%0b count=%0d exp 0 1", start_driving_main, count);
        end
        tick();
        assertCount++; if (start_driving_main !== 1'b1 || num_y_m !== 32'hFFFFFFCE) begin
            failCount++; $display("[TB] FAIL zero_next start=%0b y=%h exp 1 ffffffce", start_driving_main, num_y_m);
        end
        if (sb.size() != 0) sbExp = sb.pop_front(); else sbExp = '1;
        sbGot = outs();
        assertCount++; if (sbGot !== sbExp) begin failCount++; $display("[TB] FAIL zero_data got=%h exp=%h", sbGot, sbExp); end
        finish = 1'b1;
        tick();
        finish = 1'b0;
        tick();
    endtask

    task automatic test_error_fault();
        push_cmd(mk(32'd2000, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5));
        push_cmd(mk(32'd2001, 32'd11, 0, 0, 0, 0));
        push_cmd(mk(32'd2002, 32'd12, 0, 0, 0, 0));
        push_cmd(mk(32'd2003, 32'd13, 0, 0, 0, 0));
        in_valid = 1'b0;
        if (sb.size() != 0) sbExp = sb.pop_front(); else sbExp = '1;
        sbGot = outs();
        assertCount++; if (start_driving_main !== 1'b1 || count !== 3'd3 || sbGot !== sbExp) begin
            failCount++; $display("[TB] FAIL err_setup start=%0b count=%0d data=%h exp 1 3 %h", start_driving_main, count, sbGot, sbExp);
        end
        error = 1'b1; finish = 1'b1;
        tick();
        error = 1'b0; finish = 1'b0;
        sb.delete();
        assertCount++; if (fault !== 1'b1 || count !== 3'd0 || start_driving_main !== 1'b0 || in_ready !== 1'b0) begin
            failCount++; $display("[TB] FAIL err_fault fault=%0b count=%0d start=%0b ready=%0b exp 1 0 0 0", fault, count, start_driving_main, in_ready);
        end
        assertCount++; if (outs() !== sbExp) begin failCount++; $display("[TB] FAIL err_hold got=%h exp=%h", outs(), sbExp); end
        {in_speed, in_num_x, in_num_y, in_num_z, in_num_e0, in_num_e1} = mk(32'd9, 32'd9, 0, 0, 0, 0);
        in_valid = 1'b1; finish = 1'b1;
        tick(); tick();
        in_valid = 1'b0; finish = 1'b0;
        assertCount++; if (count !== 3'd0 || fault !== 1'b1) begin failCount++; $display("[TB] FAIL err_block count=%0d fault=%0b exp 0 1", count, fault); end
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        assertCount++; if (fault !== 1'b0 || in_ready !== 1'b1 || start_driving_main !== 1'b0) begin
            failCount++; $display("[TB] FAIL err_clear fault=%0b ready=%0b start=%0b exp 0 1 0", fault, in_ready, start_driving_main);
        end
        tick();
        assertCount++; if (start_driving_main !== 1'b0 || busy !== 1'b0) begin
            failCount++; $display("[TB] FAIL err_after start=%0b busy=%0b exp 0 0", start_driving_main, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        push_cmd(mk(32'd3000, 32'd31, 0, 0, 0, 0));
        push_cmd(mk(32'd3001, 32'd32, 0, 0, 0, 0));
        push_cmd(mk(32'd3002, 32'd33, 0, 0, 0, 0));
        in_valid = 1'b0;
        assertCount++; if (start_driving_main !== 1'b1 || count !== 3'd2) begin
            failCount++; $display("[TB] FAIL rst_setup start=%0b count=%0d exp 1 2", start_driving_main, count);
        end
        reset = 1'b1;
        tick();
        sb.delete();
        assertCount++; if (start_driving_main !== 1'b0 || count !== 3'd0 || busy !== 1'b0 || fault !== 1'b0) begin
            failCount++; $display("[TB] FAIL rst_mid start=%0b count=%0d busy=%0b fault=%0b exp 0 0 0 0", start_driving_main, count, busy, fault);
        end
        assertCount++; if (outs() !== 192'd0 || in_ready !== 1'b0) begin
            failCount++; $display("[TB] FAIL rst_outs data=%h ready=%0b exp 0 0", outs(), in_ready);
        end
        reset = 1'b0;
        tick(); tick();
        assertCount++; if (start_driving_main !== 1'b0 || in_ready !== 1'b1) begin
            failCount++; $display("[TB] FAIL rst_after start=%0b ready=%0b exp 0 1", start_driving_main, in_ready);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) begin
            push_cmd(mk($urandom, $urandom | 32'd1, $urandom, $urandom, $urandom, $urandom));
            push_cmd(mk($urandom, $urandom, $urandom | 32'd1, $urandom, $urandom, $urandom));
            in_valid = 1'b0;
            for (int m = 0; m < 2; m++) begin
                if (m == 1) tick();
                if (sb.size() != 0) sbExp = sb.pop_front(); else sbExp = '1;
                sbGot = outs();
                assertCount++; if (start_driving_main !== 1'b1 || sbGot !== sbExp) begin
                    failCount++; $display("[TB] FAIL wrap[%0d.%0d] start=%0b data=%h exp 1 %h", i, m, start_driving_main, sbGot, sbExp);
                end
                repeat ($urandom_range(0, 2)) tick();
                finish = 1'b1;
                tick();
                finish = 1'b0;
                tick();
            end
        end
        assertCount++; if (count !== 3'd0 || busy !== 1'b0 || sb.size() != 0) begin
            failCount++; $display("[TB] FAIL wrap_end count=%0d busy=%0b left=%0d exp 0 0 0", count, busy, sb.size());
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        test_reset();
        test_idle_ignore();
        test_single_move();
        test_backpressure();
        test_zero_move();
        test_error_fault();
        test_reset_mid_run();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
